// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stall, branch flush,
// data-memory freeze, plus stall/flush performance counters.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   id_rs1_i/id_rs2_i        ID source register indices
//   id_rs1_used_i/_rs2_      ID instruction reads that source
//   ex_mem_read_i, ex_rd_i   EX instruction is a load, and its destination
//   ex_branch_taken_i        EX resolved a taken branch or jump
//   dmem_req_i/dmem_ready_i  MEM access outstanding / completing
//   pc_hold_o                PC keeps its value
//   pipeline_stop_o          IF/ID holds
//   pipeline_stop_branch_o   IF/ID loads the invalid marker
//   id_ex_bubble_o           ID/EX loads a NOP
//   pipeline_freeze_o        every stage register holds
//   state_o                  RUN=0, FLUSH=1, MEM_WAIT=2
//   stall_cnt_o/flush_cnt_o  performance counters (wrap)
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_hold_o,
   output logic             pipeline_stop_o,
   output logic             pipeline_stop_branch_o,
   output logic             id_ex_bubble_o,
   output logic             pipeline_freeze_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t     state, ret_state, eff_state;
   state_t     nxt_state, nxt_ret;
   logic [2:0] rem, nxt_rem;

   logic freeze, lu, inc_flush;
   logic c_hold, c_stop, c_stop_br, c_bubble, c_freeze;

   assign freeze = dmem_req_i & ~dmem_ready_i;

   // x0 is hardwired, so a load targeting it never creates a dependency
   assign lu = ex_mem_read_i & (ex_rd_i != 5'd0) &
               ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

   // Once the wait ends, behave as the state that was interrupted
   assign eff_state = (state == MEM_WAIT) ? ret_state : state;

   always_comb begin
      c_hold    = 1'b0;
      c_stop    = 1'b0;
      c_stop_br = 1'b0;
      c_bubble  = 1'b0;
      c_freeze  = 1'b0;
      inc_flush = 1'b0;
      nxt_state = state;
      nxt_ret   = ret_state;
      nxt_rem   = rem;
      if (freeze) begin
         // EX and ID are held, so branch/lu get re-evaluated afterwards
         c_freeze  = 1'b1;
         c_hold    = 1'b1;
         c_stop    = 1'b1;
         nxt_state = MEM_WAIT;
         nxt_ret   = eff_state;
      end else begin
         case (eff_state)
            RUN: begin
               nxt_state = RUN;
               if (ex_branch_taken_i) begin
                  // ID holds a wrong-path instruction: load-use is moot
                  c_stop_br = 1'b1;
                  c_bubble  = 1'b1;
                  inc_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     nxt_state = FLUSH;
                     nxt_rem   = 3'(FLUSH_CYCLES - 1);
                  end
               end else if (lu) begin
                  c_hold   = 1'b1;
                  c_stop   = 1'b1;
                  c_bubble = 1'b1;
               end
            end
            FLUSH: begin
               c_stop_br = 1'b1;
               c_bubble  = 1'b1;
               if (rem <= 3'd1) begin
                  nxt_state = RUN;
               end else begin
                  nxt_state = FLUSH;
                  nxt_rem   = rem - 3'd1;
               end
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   assign pc_hold_o              = ~rst & c_hold;
   assign pipeline_stop_o        = ~rst & c_stop;
   assign pipeline_stop_branch_o = ~rst & c_stop_br;
   assign id_ex_bubble_o         = ~rst & c_bubble;
   assign pipeline_freeze_o      = ~rst & c_freeze;
   assign state_o                = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         ret_state   <= RUN;
         rem         <= 3'd0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         state     <= nxt_state;
         ret_state <= nxt_ret;
         rem       <= nxt_rem;
         if (c_stop)
            stall_cnt_o <= stall_cnt_o + 1'b1;
         if (inc_flush)
            flush_cnt_o <= flush_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES 2 and 3)
// share one stimulus stream; outputs are sampled 1ns after the falling edge.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic        used1, used2, mrd, br, req, rdy;

   logic        h2, s2, sb2, b2, f2;
   logic [1:0]  st2;
   logic [31:0] sc2, fc2;
   logic        h3, s3, sb3, b3, f3;
   logic [1:0]  st3;
   logic [31:0] sc3, fc3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u2 (
      .clk(clk), .rst(rst),
      .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_rs1_used_i(used1), .id_rs2_used_i(used2),
      .ex_mem_read_i(mrd), .ex_rd_i(rd),
      .ex_branch_taken_i(br),
      .dmem_req_i(req), .dmem_ready_i(rdy),
      .pc_hold_o(h2), .pipeline_stop_o(s2),
      .pipeline_stop_branch_o(sb2), .id_ex_bubble_o(b2),
      .pipeline_freeze_o(f2), .state_o(st2),
      .stall_cnt_o(sc2), .flush_cnt_o(fc2)
   );

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) u3 (
      .clk(clk), .rst(rst),
      .id_rs1_i(rs1), .id_rs2_i(rs2),
      .id_rs1_used_i(used1), .id_rs2_used_i(used2),
      .ex_mem_read_i(mrd), .ex_rd_i(rd),
      .ex_branch_taken_i(br),
      .dmem_req_i(req), .dmem_ready_i(rdy),
      .pc_hold_o(h3), .pipeline_stop_o(s3),
      .pipeline_stop_branch_o(sb3), .id_ex_bubble_o(b3),
      .pipeline_freeze_o(f3), .state_o(st3),
      .stall_cnt_o(sc3), .flush_cnt_o(fc3)
   );

   // control vector order: {pc_hold, stop, stop_branch, bubble, freeze}
   wire [4:0] ctl2 = {h2, s2, sb2, b2, f2};
   wire [4:0] ctl3 = {h3, s3, sb3, b3, f3};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      used1 = 1'b0; used2 = 1'b0; mrd = 1'b0; br = 1'b0;
      req = 1'b0; rdy = 1'b0;
   endtask

   // next cycle: inputs are applied on the falling edge, checks follow at +1
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cyc(); #1;
      chk("rst_ctl_forced", {27'd0, ctl2}, 32'h0);
      cyc(); idle(); #1;
      chk("rst_state", {30'd0, st2}, 32'd0);
      chk("rst_stall", sc2, 32'd0);
      chk("rst_flush", fc2, 32'd0);
      chk("rst_ctl", {27'd0, ctl2}, 32'h0);

      // load-use on rs1
      cyc(); mrd = 1'b1; rd = 5'd5; rs1 = 5'd5; used1 = 1'b1; #1;
      chk("lu_rs1_ctl", {27'd0, ctl2}, 32'b11010);
      chk("lu_rs1_state", {30'd0, st2}, 32'd0);
      cyc(); idle(); #1;
      chk("lu_after_ctl", {27'd0, ctl2}, 32'h0);
      chk("lu_stall_cnt", sc2, 32'd1);
      chk("lu_after_state", {30'd0, st2}, 32'd0);

      // x0 destination never stalls
      cyc(); mrd = 1'b1; rd = 5'd0; rs1 = 5'd0; used1 = 1'b1; #1;
      chk("x0_no_stall", {27'd0, ctl2}, 32'h0);
      // matching but unused rs2
      cyc(); idle(); mrd = 1'b1; rd = 5'd7; rs2 = 5'd7; #1;
      chk("rs2_unused", {27'd0, ctl2}, 32'h0);
      // same, now used
      cyc(); used2 = 1'b1; #1;
      chk("lu_rs2_ctl", {27'd0, ctl2}, 32'b11010);
      cyc(); idle(); #1;
      chk("lu_rs2_stall", sc2, 32'd2);

      // taken branch, FLUSH_CYCLES=2
      cyc(); br = 1'b1; #1;
      chk("br_c1_ctl", {27'd0, ctl2}, 32'b00110);
      chk("br_c1_state", {30'd0, st2}, 32'd0);
      cyc(); idle(); #1;
      chk("br_c2_ctl", {27'd0, ctl2}, 32'b00110);
      chk("br_c2_state", {30'd0, st2}, 32'd1);
      chk("br_flush_cnt", fc2, 32'd1);
      cyc(); #1;
      chk("br_c3_ctl", {27'd0, ctl2}, 32'h0);
      chk("br_c3_state", {30'd0, st2}, 32'd0);
      cyc(); #1;

      // branch and load-use together: flush wins
      cyc(); br = 1'b1; mrd = 1'b1; rd = 5'd9; rs1 = 5'd9; used1 = 1'b1; #1;
      chk("brlu_ctl", {27'd0, ctl2}, 32'b00110);
      cyc(); idle(); #1;
      chk("brlu_stall", sc2, 32'd2);
      chk("brlu_flush", fc2, 32'd2);
      cyc(); cyc(); cyc(); #1;

      // memory wait during FLUSH, FLUSH_CYCLES=3
      rst = 1'b1;
      cyc(); idle(); #1;
      chk("mw_rst_stall", sc3, 32'd0);
      cyc(); br = 1'b1; #1;
      chk("mw_br_ctl", {27'd0, ctl3}, 32'b00110);
      cyc(); idle(); req = 1'b1; #1;
      chk("mw_f1_ctl", {27'd0, ctl3}, 32'b11001);
      chk("mw_f1_state", {30'd0, st3}, 32'd1);
      cyc(); br = 1'b1; #1;
      chk("mw_f2_ctl_br_ignored", {27'd0, ctl3}, 32'b11001);
      chk("mw_f2_state", {30'd0, st3}, 32'd2);
      cyc(); br = 1'b0; #1;
      chk("mw_f3_ctl", {27'd0, ctl3}, 32'b11001);
      cyc(); #1;
      chk("mw_f4_ctl", {27'd0, ctl3}, 32'b11001);
      chk("mw_f4_state", {30'd0, st3}, 32'd2);
      cyc(); req = 1'b0; #1;
      chk("mw_resume_ctl", {27'd0, ctl3}, 32'b00110);
      chk("mw_resume_state", {30'd0, st3}, 32'd2);
      cyc(); #1;
      chk("mw_third_ctl", {27'd0, ctl3}, 32'b00110);
      chk("mw_third_state", {30'd0, st3}, 32'd1);
      cyc(); req = 1'b1; rdy = 1'b1; #1;
      chk("mw_done_ctl", {27'd0, ctl3}, 32'h0);
      chk("mw_done_state", {30'd0, st3}, 32'd0);
      chk("mw_stall_cnt", sc3, 32'd4);
      chk("mw_flush_cnt", fc3, 32'd1);

      // reset in the middle of a flush
      cyc(); idle(); br = 1'b1; #1;
      cyc(); br = 1'b1; rst = 1'b1; #1;
      chk("rf_in_flush_state", {30'd0, st3}, 32'd1);
      chk("rf_forced_ctl", {27'd0, ctl3}, 32'h0);
      cyc(); idle(); #1;
      chk("rf_state", {30'd0, st3}, 32'd0);
      chk("rf_stall", sc3, 32'd0);
      chk("rf_flush", fc3, 32'd0);
      chk("rf_ctl", {27'd0, ctl3}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard sequencer for the 5-stage pipeline.
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Drives the stall and flush controls of the IF/ID register (pipeline_stop / pipeline_stop_branch), the PC hold, the ID/EX bubble insert and a global freeze.
- Keeps a small FSM for multi-cycle flush and memory wait, plus two performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles pipeline_stop_branch_o stays asserted per taken branch, counting the resolve cycle; legal range 1..4.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs1_i  in  5  rs1 index of the instruction in ID
- id_rs2_i  in  5  rs2 index of the instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of the EX instruction
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump this cycle
- dmem_req_i  in  1  MEM stage has an outstanding data access
- dmem_ready_i  in  1  data memory completes the access this cycle
- pc_hold_o  out  1  PC keeps its value
- pipeline_stop_o  out  1  IF/ID holds its contents (load-use / freeze)
- pipeline_stop_branch_o  out  1  IF/ID loads the invalid marker (flush)
- id_ex_bubble_o  out  1  ID/EX loads a NOP
- pipeline_freeze_o  out  1  all stage registers hold
- state_o  out  2  FSM state: RUN=0, FLUSH=1, MEM_WAIT=2
- stall_cnt_o  out  CNT_W  cycles with pipeline_stop_o=1
- flush_cnt_o  out  CNT_W  taken-branch events accepted

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=RUN, flush counter=0, saved return state=RUN, stall_cnt_o=0, flush_cnt_o=0.
  - While rst is high, all control outputs are forced to 0.
- Control outputs are combinational from state and inputs, so they act in the same cycle. State and counters are registered.
- Hazard terms:
  - freeze = dmem_req_i & ~dmem_ready_i.
  - lu = ex_mem_read_i & (ex_rd_i!=0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- Priority is freeze > branch flush > load-use.
- Freeze, in any state:
  - pipeline_freeze_o=1, pc_hold_o=1, pipeline_stop_o=1; all other control outputs 0.
  - ex_branch_taken_i and lu are ignored; they are re-evaluated once freeze drops, because EX and ID are held.
  - The return state (RUN or FLUSH) is saved and the next state is MEM_WAIT.
  - The FLUSH countdown is paused.
- MEM_WAIT:
  - Stays while freeze=1.
  - When freeze=0, outputs follow the rules of the saved return state in that same cycle, and the next state is computed as if in that state.
- RUN with ex_branch_taken_i=1:
  - pipeline_stop_branch_o=1, id_ex_bubble_o=1, pc_hold_o=0, pipeline_stop_o=0.
  - flush_cnt_o increments.
  - If FLUSH_CYCLES>1: next state FLUSH with remaining=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - A load-use in the same cycle is ignored, because the ID instruction is wrong-path.
- RUN with lu=1 and no branch: pc_hold_o=1, pipeline_stop_o=1, id_ex_bubble_o=1. Single cycle; no state change, since the load leaves EX at the next edge.
- RUN with no hazard: all control outputs 0.
- FLUSH:
  - pipeline_stop_branch_o=1, id_ex_bubble_o=1, pc_hold_o=0.
  - remaining decrements each non-frozen cycle; when it reaches 1, next state is RUN.
  - ex_branch_taken_i and lu are ignored.
- Counters:
  - stall_cnt_o increments on every cycle with pipeline_stop_o=1, freeze included.
  - Both counters wrap modulo 2^CNT_W.
- Reset mid-operation: returns to RUN from any state on the next edge; any pending flush or wait is discarded.
- ex_rd_i=0 never raises lu, because x0 is hardwired.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_used_i=1 for one cycle -> pc_hold_o=pipeline_stop_o=id_ex_bubble_o=1 that cycle only; stall_cnt_o=1; state_o stays 0.
- x0 and unused operands:
  - ex_rd_i=0 with id_rs1_i=0 -> no stall.
  - ex_rd_i=7, id_rs2_i=7, id_rs2_used_i=0 -> no stall.
- Branch with FLUSH_CYCLES=2: ex_branch_taken_i=1 for one cycle -> pipeline_stop_branch_o=1 for exactly 2 cycles; state_o sequence 0,1,0; flush_cnt_o=1.
- Branch plus load-use in the same cycle -> flush only; pipeline_stop_o=0; stall_cnt_o unchanged.
- Memory wait during FLUSH (FLUSH_CYCLES=3):
  - Stimulus: dmem_req_i=1, dmem_ready_i=0 for 4 cycles starting at flush cycle 2.
  - Response: pipeline_freeze_o=1 for those 4 cycles; state_o=2; the flush then resumes and completes its third cycle; stall_cnt_o=4.
- Reset mid-FLUSH: rst=1 for one cycle -> next cycle state_o=0, both counters 0, all control outputs 0.
